// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: channel indices and default timing.
package btn_pkg;

    localparam int BTN_R   = 0;
    localparam int BTN_U   = 1;
    localparam int BTN_D   = 2;
    localparam int BTN_L   = 3;
    localparam int NUM_BTN = 4;

    localparam int DEF_SAMPLE_DIV       = 16;
    localparam int DEF_DEBOUNCE_SAMPLES = 4;
    localparam int DEF_REPEAT_DELAY     = 32;
    localparam int DEF_REPEAT_PERIOD    = 8;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, tick-sampled shift register, level and press pulse.
// Optional auto-repeat counter is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
    parameter int REPEAT_DELAY     = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD    = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic pulse_next
);

    logic                        sync1;
    logic                        sync2;
    logic [DEBOUNCE_SAMPLES-1:0] sr;
    logic [DEBOUNCE_SAMPLES-1:0] sr_next;
    logic                        level_next;
    logic                        press;

    // Level decides on the shift register including the sample taken this tick,
    // so the Nth equal sample changes the level on the same edge.
    assign sr_next = {sr[DEBOUNCE_SAMPLES-2:0], sync2};

    always_comb begin
        level_next = level;
        if (tick) begin
            if (&sr_next) begin
                level_next = 1'b1;
            end else if (~|sr_next) begin
                level_next = 1'b0;
            end
        end
    end

    assign press = level_next & ~level;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             rpt_fire;

    // Ticks are counted from the press edge; the first interval is the long delay.
    assign rpt_fire = tick & level & level_next &
                      (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!level_next) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (tick && level) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign pulse_next = press | rpt_fire;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
    assign pulse_next = press;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sr    <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                sr <= sr_next;
            end
            level <= level_next;
            pulse <= pulse_next;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Four-button conditioner: shared sample tick, per-channel debounce, registered OR of pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module btn_conditioner #(
    parameter int NUM_BTN          = btn_pkg::NUM_BTN,
    parameter int SAMPLE_DIV       = btn_pkg::DEF_SAMPLE_DIV,
    parameter int DEBOUNCE_SAMPLES = btn_pkg::DEF_DEBOUNCE_SAMPLES,
    parameter int REPEAT_DELAY     = btn_pkg::DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD    = btn_pkg::DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               btn_any
);

    // No valid/ready handshake: btn_pulse and btn_any are one-cycle strobes that
    // the consumer must sample on every clock; nothing is held or back-pressured.

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] pulse_next;

    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
            .REPEAT_DELAY     (REPEAT_DELAY),
            .REPEAT_PERIOD    (REPEAT_PERIOD)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .pulse      (btn_pulse[i]),
            .pulse_next (pulse_next[i])
        );
    end

    // Built from the pre-register pulses so it lands in the same cycle as btn_pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_any <= 1'b0;
        end else begin
            btn_any <= |pulse_next;
        end
    end

endmodule
